// File: rtl/write_sdram_if.sv
// Avalon-MM write bus between the burst writer and the HPS FPGA-to-SDRAM port 0.
interface write_sdram_if;
  logic [28:0] address;
  logic [7:0]  burstCount;
  logic        write;
  logic [63:0] writeData;
  logic [7:0]  byteEnable;
  logic        waitRequest;

  modport master (
    output address, burstCount, write, writeData, byteEnable,
    input  waitRequest
  );

  modport slave (
    input  address, burstCount, write, writeData, byteEnable,
    output waitRequest
  );
endinterface

// File: rtl/write_sdram.sv
// Avalon-MM burst write master: writes numBursts fixed-length bursts of the
// pattern seed+beat_index into HPS DDR3 starting at BASE_ADDR.
module write_sdram #(
  parameter int unsigned BURST_LEN = 16,
  parameter logic [28:0] BASE_ADDR = 29'h0200_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       numBursts,
  input  logic [63:0]       seed,
  write_sdram_if.master     avm,
  output logic              busy,
  output logic              done,
  output logic [23:0]       beatsWritten
);

  localparam logic [7:0]  BURST_CNT = 8'(BURST_LEN);
  localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [28:0] ADDR_STEP = 29'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [28:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [23:0] beats_q, beats_d;
  logic [7:0]  beat_idx_q, beat_idx_d;
  logic [15:0] bursts_left_q, bursts_left_d;

  // State and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= BASE_ADDR;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      beats_q       <= '0;
      beat_idx_q    <= '0;
      bursts_left_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      write_q       <= write_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      beats_q       <= beats_d;
      beat_idx_q    <= beat_idx_d;
      bursts_left_q <= bursts_left_d;
    end
  end

  // Next state and next output values; outputs are computed one cycle
  // ahead so every Avalon signal comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    write_d       = write_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    beats_d       = beats_q;
    beat_idx_d    = beat_idx_q;
    bursts_left_d = bursts_left_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d        = BASE_ADDR;
          wdata_d       = seed;
          beats_d       = '0;
          beat_idx_d    = '0;
          bursts_left_d = numBursts;
          if (numBursts != 16'd0) begin
            state_d = S_WRITE;
            write_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_WRITE: begin
        if (!avm.waitRequest) begin
          // wdata tracks seed + global beat index by incrementing per accept.
          wdata_d    = wdata_q + 64'd1;
          beats_d    = beats_q + 24'd1;
          beat_idx_d = beat_idx_q + 8'd1;
          if (beat_idx_q == LAST_BEAT) begin
            if (bursts_left_q > 16'd1) begin
              bursts_left_d = bursts_left_q - 16'd1;
              addr_d        = addr_q + ADDR_STEP;
              beat_idx_d    = '0;
            end else begin
              state_d = S_DONE;
              write_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        write_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign avm.address    = addr_q;
  assign avm.burstCount = BURST_CNT;
  assign avm.write      = write_q;
  assign avm.writeData  = wdata_q;
  assign avm.byteEnable = 8'hFF;
  assign busy           = busy_q;
  assign done           = done_q;
  assign beatsWritten   = beats_q;

endmodule
